// File: rtl/param_string_pkg.sv
// Shared types for the parameter-string streaming controller.
package param_string_pkg;

    typedef logic [7:0] char_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Index width wide enough to hold the longer string's length.
    function automatic int idx_width(input int len_a, input int len_b);
        int longest;
        longest = (len_a > len_b) ? len_a : len_b;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/param_string_char_sel.sv
// Character lookup for both strings: hides packed-vector vs string-type indexing.
module param_string_char_sel
    import param_string_pkg::*;
#(
    parameter              STR_A = "System",
    parameter string       STR_B = "Verilog",
    localparam int         LEN_A = $bits(STR_A) / 8,
    localparam int         LEN_B = STR_B.len(),
    localparam int         IDX_W = idx_width(LEN_A, LEN_B)
) (
    input  src_e             src_i,
    input  logic [IDX_W-1:0] idx_i,
    output char_t            char_o,
    output logic             last_o
);

    if (LEN_A == 0 || LEN_B == 0) begin : g_len_err
        $error("param_string_char_sel: STR_A and STR_B must be non-empty");
    end

    char_t rom_a [LEN_A];
    char_t rom_b [LEN_B];

    // Packed string: character 0 sits in the most significant byte.
    for (genvar k = 0; k < LEN_A; k++) begin : g_rom_a
        assign rom_a[k] = STR_A[8*(LEN_A-1-k) +: 8];
    end

    for (genvar k = 0; k < LEN_B; k++) begin : g_rom_b
        assign rom_b[k] = STR_B[k];
    end

    always_comb begin
        char_o = '0;
        last_o = 1'b0;
        if (src_i == SRC_A) begin
            for (int k = 0; k < LEN_A; k++) begin
                if (idx_i == IDX_W'(k)) char_o = rom_a[k];
            end
            last_o = (idx_i == IDX_W'(LEN_A - 1));
        end else begin
            for (int k = 0; k < LEN_B; k++) begin
                if (idx_i == IDX_W'(k)) char_o = rom_b[k];
            end
            last_o = (idx_i == IDX_W'(LEN_B - 1));
        end
    end

endmodule

// File: rtl/param_string_stream_ctrl.sv
// Round-robin streamer of two parameter strings onto one valid/ready byte port,
// with a one-cycle completion ack per requester.
module param_string_stream_ctrl
    import param_string_pkg::*;
#(
    parameter        STR_A = "System",
    parameter string STR_B = "Verilog"
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_req_a,
    input  logic  i_req_b,
    output logic  o_ack_a,
    output logic  o_ack_b,
    output logic  o_busy,
    output logic  o_valid,
    input  logic  i_ready,
    output char_t o_char,
    output logic  o_last,
    output logic  o_src
);

    localparam int LEN_A = $bits(STR_A) / 8;
    localparam int LEN_B = STR_B.len();
    localparam int IDX_W = idx_width(LEN_A, LEN_B);

    state_e           state_q, state_d;
    src_e             src_q, src_d;
    src_e             prio_q, prio_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    char_t sel_char;
    logic  sel_last;
    logic  streaming;

    param_string_char_sel #(
        .STR_A (STR_A),
        .STR_B (STR_B)
    ) u_char_sel (
        .src_i  (src_q),
        .idx_i  (idx_q),
        .char_o (sel_char),
        .last_o (sel_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_A;
            prio_q  <= SRC_A;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            prio_q  <= prio_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        prio_d  = prio_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_a || i_req_b) begin
                    if (i_req_a && i_req_b) src_d = prio_q;
                    else if (i_req_a)       src_d = SRC_A;
                    else                    src_d = SRC_B;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Requests are ignored here; only the sink handshake advances.
                if (i_ready) begin
                    if (sel_last) begin
                        state_d = ST_DONE;
                        prio_d  = (src_q == SRC_A) ? SRC_B : SRC_A;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // All outputs decode from registered state, so reset clears them at once.
    assign streaming = (state_q == ST_STREAM);
    assign o_valid   = streaming;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_char    = streaming ? sel_char : '0;
    assign o_last    = streaming && sel_last;
    assign o_src     = streaming && (src_q == SRC_B);
    assign o_ack_a   = (state_q == ST_DONE) && (src_q == SRC_A);
    assign o_ack_b   = (state_q == ST_DONE) && (src_q == SRC_B);

endmodule
